ps2_receiver: RTL

Host-side PS/2 keyboard receiver. It deserialises device-to-host frames arriving on the PS/2 clock and data lines, and checks the start, parity and stop bits. Each valid scan-code byte is presented to the processor core on the `ps2_key_pressed` / `ps2_out` pair. It sits between the board PS/2 pins and the processor's keyboard inputs, in the processor clock domain.

---
 rtl/ps2_receiver.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/ps2_receiver.sv
// Host-side PS/2 device-to-host frame receiver with clock-line glitch filter and frame timeout.
// Optional macro PS2_RX_BREAK_FILTER_EN suppresses F0-prefixed break sequences.
module ps2_receiver #(
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ps2_clock,
    input  logic       ps2_data,
    output logic       ps2_key_pressed,
    output logic [7:0] ps2_out,
    output logic       frame_error
);
    localparam int              TW          = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0]   TIMEOUT_VAL = TW'(TIMEOUT_CYCLES);
    localparam logic [3:0]      FILT_VAL    = 4'(FILTER_LEN);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DATA   = 2'd1,
        S_PARITY = 2'd2,
        S_STOP   = 2'd3
    } state_t;

    logic          clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
    logic [3:0]    filt_cnt_q, filt_cnt_d;
    logic          filt_clk_q, filt_clk_d;
    logic          filt_prev_q;
    logic          fall_s;
    logic          timeout_s;
    state_t        state_q, state_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          par_q, par_d;
    logic          par_ok_q, par_ok_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic          key_q, key_d;
    logic          err_q, err_d;
    logic [7:0]    out_q, out_d;
`ifdef PS2_RX_BREAK_FILTER_EN
    logic          brk_q, brk_d;
`endif

    // Pin synchronisers; idle level of both lines is high
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            clk_s1_q <= 1'b1;
            clk_s2_q <= 1'b1;
            dat_s1_q <= 1'b1;
            dat_s2_q <= 1'b1;
        end else begin
            clk_s1_q <= ps2_clock;
            clk_s2_q <= clk_s1_q;
            dat_s1_q <= ps2_data;
            dat_s2_q <= dat_s1_q;
        end
    end

    // Glitch filter: level flips only after FILTER_LEN consecutive differing samples
    always_comb begin
        filt_cnt_d = filt_cnt_q;
        filt_clk_d = filt_clk_q;
        if (clk_s2_q == filt_clk_q) begin
            filt_cnt_d = 4'd0;
        end else if ((filt_cnt_q + 4'd1) >= FILT_VAL) begin
            filt_clk_d = clk_s2_q;
            filt_cnt_d = 4'd0;
        end else begin
            filt_cnt_d = filt_cnt_q + 4'd1;
        end
    end

    assign fall_s = filt_prev_q & ~filt_clk_q;

    // Frame FSM, timeout counter and output staging
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        par_d     = par_q;
        par_ok_d  = par_ok_q;
        key_d     = 1'b0;
        err_d     = 1'b0;
        out_d     = out_q;
`ifdef PS2_RX_BREAK_FILTER_EN
        brk_d     = brk_q;
`endif
        timeout_s = (state_q != S_IDLE) && (tcnt_q == TIMEOUT_VAL) && !fall_s;

        if (state_q == S_IDLE || fall_s) begin
            tcnt_d = {TW{1'b0}};
        end else if (tcnt_q != TIMEOUT_VAL) begin
            tcnt_d = tcnt_q + TW'(1'b1);
        end else begin
            tcnt_d = tcnt_q;
        end

        if (timeout_s) begin
            state_d = S_IDLE;
            err_d   = 1'b1;
            shift_d = 8'h00;
            tcnt_d  = {TW{1'b0}};
`ifdef PS2_RX_BREAK_FILTER_EN
            brk_d   = 1'b0;
`endif
        end else if (fall_s) begin
            case (state_q)
                S_IDLE: begin
                    if (!dat_s2_q) begin
                        state_d   = S_DATA;
                        bit_cnt_d = 3'd0;
                        par_d     = 1'b0;
                    end else begin
                        state_d   = S_IDLE;
                    end
                end
                S_DATA: begin
                    shift_d   = {dat_s2_q, shift_q[7:1]};
                    par_d     = par_q ^ dat_s2_q;
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = S_PARITY;
                    end else begin
                        state_d = S_DATA;
                    end
                end
                S_PARITY: begin
                    par_ok_d = par_q ^ dat_s2_q;
                    state_d  = S_STOP;
                end
                S_STOP: begin
                    state_d = S_IDLE;
                    if (dat_s2_q && par_ok_q) begin
`ifdef PS2_RX_BREAK_FILTER_EN
                        // E0 passes through untouched even inside a break sequence
                        if (shift_q == 8'hE0) begin
                            key_d = 1'b1;
                            out_d = shift_q;
                        end else if (brk_q) begin
                            brk_d = 1'b0;
                        end else if (shift_q == 8'hF0) begin
                            brk_d = 1'b1;
                        end else begin
                            key_d = 1'b1;
                            out_d = shift_q;
                        end
`else
                        key_d = 1'b1;
                        out_d = shift_q;
`endif
                    end else begin
                        err_d = 1'b1;
`ifdef PS2_RX_BREAK_FILTER_EN
                        brk_d = 1'b0;
`endif
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // State and output registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            filt_cnt_q  <= 4'd0;
            filt_clk_q  <= 1'b1;
            filt_prev_q <= 1'b1;
            state_q     <= S_IDLE;
            bit_cnt_q   <= 3'd0;
            shift_q     <= 8'h00;
            par_q       <= 1'b0;
            par_ok_q    <= 1'b0;
            tcnt_q      <= {TW{1'b0}};
            key_q       <= 1'b0;
            err_q       <= 1'b0;
            out_q       <= 8'h00;
        end else begin
            filt_cnt_q  <= filt_cnt_d;
            filt_clk_q  <= filt_clk_d;
            filt_prev_q <= filt_clk_q;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            par_q       <= par_d;
            par_ok_q    <= par_ok_d;
            tcnt_q      <= tcnt_d;
            key_q       <= key_d;
            err_q       <= err_d;
            out_q       <= out_d;
        end
    end

`ifdef PS2_RX_BREAK_FILTER_EN
    // Break-sequence flag
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            brk_q <= 1'b0;
        end else begin
            brk_q <= brk_d;
        end
    end
`endif

    assign ps2_key_pressed = key_q;
    assign frame_error     = err_q;
    assign ps2_out         = out_q;

endmodule
